if_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 5-stage pipeline. It owns the PC, issues fetches to instruction memory over a req/ack handshake, and buffers one returned instruction. That instruction is presented to the control unit as `if_instr` for hazard detection. The stage then advances it into the ID register `instr` under control of the stall (`wpcir`) and branch/jump redirect signals.

---
 rtl/if_stage_pkg.sv | 16 +
 rtl/if_stage_ifid_reg.sv | 35 +++
 rtl/if_stage.sv | 102 ++++++++++
 tb/tb_if_stage.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared encodings and helpers for the instruction-fetch stage
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        IF_FETCH = 1'b0,
        IF_FLUSH = 1'b1
    } if_state_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc_in);
        return pc_in + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_ifid_reg.sv
// rtl/if_stage_ifid_reg.sv - IF/ID pipeline register with hold, flush and bubble insertion
module ifid_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        flush,
    input  logic        load_valid,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc4,
    output logic [31:0] instr,
    output logic [31:0] id_pc4
);

    // Flush and bubble only replace the instruction; id_pc4 of a NOP is don't-care.
    always_ff @(posedge clk) begin
        if (!rst) begin
            instr  <= NOP;
            id_pc4 <= 32'h0000_0000;
        end else if (hold) begin
            instr  <= instr;
        end else if (flush) begin
            instr  <= NOP;
        end else if (load_valid) begin
            instr  <= load_instr;
            id_pc4 <= load_pc4;
        end else begin
            instr  <= NOP;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - PC, fetch handshake, one-entry fetch buffer and IF/ID register
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP      = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wpcir,
    input  logic        branch,
    input  logic [31:0] branch_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instr,
    output logic [31:0] instr,
    output logic [31:0] id_pc4,
    output logic [31:0] pc
);

    if_state_t   state;
    logic [31:0] fb_instr;
    logic [31:0] fb_pc4;
    logic        fb_valid;
    logic [31:0] kill_addr;
    logic        consume;
    logic        redirect;
    logic        accept;

    // A stall masks the redirect entirely, so ID keeps its instruction while stalled.
    assign redirect = branch & ~wpcir;
    assign consume  = fb_valid & ~wpcir & ~branch;
    assign accept   = imem_req & imem_ack;

    always_comb begin
        imem_req = 1'b0;
        if (rst) begin
            imem_req = (state == IF_FLUSH) | ~fb_valid | consume;
        end
    end

    assign imem_addr = (state == IF_FLUSH) ? kill_addr : pc;
    assign if_instr  = fb_valid ? fb_instr : NOP;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc        <= RESET_PC;
            fb_valid  <= 1'b0;
            fb_instr  <= NOP;
            fb_pc4    <= 32'h0000_0000;
            kill_addr <= 32'h0000_0000;
            state     <= IF_FETCH;
        end else begin
            case (state)
                IF_FETCH: begin
                    if (redirect) begin
                        pc       <= branch_pc;
                        fb_valid <= 1'b0;
                        // An outstanding request must still complete; its data is dropped in FLUSH.
                        if (imem_req && !imem_ack) begin
                            kill_addr <= pc;
                            state     <= IF_FLUSH;
                        end
                    end else if (accept) begin
                        fb_instr <= imem_rdata;
                        fb_pc4   <= pc_plus4(pc);
                        fb_valid <= 1'b1;
                        pc       <= pc_plus4(pc);
                    end else if (consume) begin
                        fb_valid <= 1'b0;
                    end
                end
                IF_FLUSH: begin
                    if (redirect) begin
                        pc <= branch_pc;
                    end
                    if (imem_ack) begin
                        state <= IF_FETCH;
                    end
                end
                default: state <= IF_FETCH;
            endcase
        end
    end

    ifid_reg #(
        .NOP(NOP)
    ) u_ifid_reg (
        .clk       (clk),
        .rst       (rst),
        .hold      (wpcir),
        .flush     (redirect),
        .load_valid(fb_valid),
        .load_instr(fb_instr),
        .load_pc4  (fb_pc4),
        .instr     (instr),
        .id_pc4    (id_pc4)
    );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        wpcir;
    logic        branch;
    logic [31:0] branch_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_instr;
    logic [31:0] instr;
    logic [31:0] id_pc4;
    logic [31:0] pc;

    int   checks   = 0;
    int   failures = 0;
    int   lat      = 0;
    int   cnt      = 0;
    logic extra_ack;

    localparam logic [31:0] NOPW = 32'h0000_0000;

    always #5 clk = ~clk;

    // Memory model: ack after the request has been held for lat cycles; extra_ack forces a stray ack.
    assign imem_ack   = extra_ack | (imem_req && (cnt >= lat));
    assign imem_rdata = extra_ack ? 32'hDEAD_BEEF : (imem_addr | 32'hA000_0000);

    always @(posedge clk) begin
        if (!imem_req || imem_ack) cnt <= 0;
        else                       cnt <= cnt + 1;
    end

    if_stage dut (
        .clk       (clk),
        .rst       (rst),
        .wpcir     (wpcir),
        .branch    (branch),
        .branch_pc (branch_pc),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .if_instr  (if_instr),
        .instr     (instr),
        .id_pc4    (id_pc4),
        .pc        (pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; wpcir = 1'b0; branch = 1'b0; branch_pc = 32'h0; extra_ack = 1'b0;
        tick; tick;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_instr", instr, NOPW);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc4", id_pc4, 32'h0);
        chk("rst_ifinstr", if_instr, NOPW);

        rst = 1'b1; #1;
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        tick;
        chk("s0_instr", instr, NOPW);
        chk("s0_ifinstr", if_instr, 32'hA000_0000);
        chk("s0_pc", pc, 32'h4);
        tick;
        chk("s1_instr", instr, 32'hA000_0000);
        chk("s1_pc4", id_pc4, 32'h4);
        tick;
        chk("s2_instr", instr, 32'hA000_0004);
        chk("s2_pc4", id_pc4, 32'h8);
        chk("s2_ifinstr", if_instr, 32'hA000_0008);
        chk("s2_pc", pc, 32'hC);

        wpcir = 1'b1; #1;
        chk("stall_noreq", {31'b0, imem_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("stall_instr", instr, 32'hA000_0004);
            chk("stall_ifinstr", if_instr, 32'hA000_0008);
            chk("stall_pc", pc, 32'hC);
        end
        wpcir = 1'b0;
        tick;
        chk("rel_instr", instr, 32'hA000_0008);
        chk("rel_pc4", id_pc4, 32'hC);
        tick;
        chk("rel2_instr", instr, 32'hA000_000C);
        chk("rel2_ifinstr", if_instr, 32'hA000_0010);

        branch = 1'b1; branch_pc = 32'h100;
        tick;
        branch = 1'b0; #1;
        chk("br_instr0", instr, NOPW);
        chk("br_pc", pc, 32'h100);
        chk("br_addr", imem_addr, 32'h100);
        tick;
        chk("br_instr1", instr, NOPW);
        chk("br_ifinstr", if_instr, 32'hA000_0100);
        tick;
        chk("br_target", instr, 32'hA000_0100);
        chk("br_pc4", id_pc4, 32'h104);

        branch = 1'b1; branch_pc = 32'h10;
        tick;
        branch = 1'b0; lat = 2; #1;
        chk("lat_req", {31'b0, imem_req}, 32'd1);
        chk("lat_addr", imem_addr, 32'h10);
        tick;
        branch = 1'b1; branch_pc = 32'h200;
        tick;
        branch = 1'b0; #1;
        chk("kill_addr", imem_addr, 32'h10);
        chk("kill_req", {31'b0, imem_req}, 32'd1);
        chk("kill_pc", pc, 32'h200);
        tick;
        chk("kill_next_addr", imem_addr, 32'h200);
        chk("kill_discard", if_instr, NOPW);
        chk("kill_instr", instr, NOPW);
        tick; tick; tick;
        chk("lat_ifinstr", if_instr, 32'hA000_0200);
        tick;
        chk("lat_instr", instr, 32'hA000_0200);
        chk("lat_pc4", id_pc4, 32'h204);

        lat = 0;
        tick;
        chk("pre_bw_ifinstr", if_instr, 32'hA000_0204);
        chk("pre_bw_pc", pc, 32'h208);
        wpcir = 1'b1; branch = 1'b1; branch_pc = 32'h300;
        tick;
        chk("bw_pc", pc, 32'h208);
        chk("bw_ifinstr", if_instr, 32'hA000_0204);
        wpcir = 1'b0;
        tick;
        branch = 1'b0;
        chk("bw2_pc", pc, 32'h300);
        chk("bw2_instr", instr, NOPW);
        tick; tick;
        chk("bw2_target", instr, 32'hA000_0300);

        lat = 2;
        tick;
        chk("mid_pc", pc, 32'h308);
        rst = 1'b0; #1;
        chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
        tick;
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_instr", instr, NOPW);
        extra_ack = 1'b1;
        tick;
        chk("late_ack_ignored", if_instr, NOPW);
        extra_ack = 1'b0; rst = 1'b1; lat = 0;
        tick;
        chk("post_rst_ifinstr", if_instr, 32'hA000_0000);
        tick;
        chk("post_rst_instr", instr, 32'hA000_0000);

        branch = 1'b1; branch_pc = 32'hFFFF_FFFC;
        tick;
        branch = 1'b0;
        chk("wrap_pc0", pc, 32'hFFFF_FFFC);
        tick;
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_ifinstr", if_instr, 32'hFFFF_FFFC);
        tick;
        chk("wrap_instr", instr, 32'hFFFF_FFFC);
        chk("wrap_pc4", id_pc4, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
